// File: rtl/dma_pcie_mdma_c2h_axis_arb_pkg.sv
// dma_pcie_mdma_c2h_axis_arb_pkg: shared CPM MDMA C2H stream types, arbiter limits and FSM states.
package dma_pcie_mdma_c2h_axis_arb_pkg;
  localparam int C2H_ARB_MAX_SRC = 8;
  localparam int C2H_DATA_W = 64;
  typedef logic [C2H_DATA_W-1:0] mdma_c2h_axis_data_t;
  typedef struct packed {
    logic [10:0] qid;
    logic [2:0]  port_id;
    logic        marker;
    logic [15:0] len;
  } mdma_c2h_axis_ctrl_t;
  typedef struct packed {
    mdma_c2h_axis_data_t data;
    mdma_c2h_axis_ctrl_t ctrl;
    logic                tlast;
    logic [5:0]          mty;
  } c2h_beat_t;
  typedef enum logic {ARB_IDLE, ARB_BUSY} c2h_arb_state_e;
endpackage

// File: rtl/dma_pcie_mdma_c2h_axis_arb_if.sv
// dma_pcie_mdma_c2h_axis_arb_if: per-source C2H stream inputs and the shared C2H stream output.
interface dma_pcie_mdma_c2h_axis_arb_if #(
  parameter int NUM_SRC = 4
);
  import dma_pcie_mdma_c2h_axis_arb_pkg::*;
  mdma_c2h_axis_data_t [NUM_SRC-1:0]      s_data;
  mdma_c2h_axis_ctrl_t [NUM_SRC-1:0]      s_ctrl;
  logic                [NUM_SRC-1:0]      s_tlast;
  logic                [NUM_SRC-1:0][5:0] s_mty;
  logic                [NUM_SRC-1:0]      s_tvalid;
  logic                [NUM_SRC-1:0]      s_tready;
  mdma_c2h_axis_data_t                    m_data;
  mdma_c2h_axis_ctrl_t                    m_ctrl;
  logic                                   m_tlast;
  logic                [5:0]              m_mty;
  logic                                   m_tvalid;
  logic                                   m_tready;
  modport slave (
    input  s_data, s_ctrl, s_tlast, s_mty, s_tvalid, m_tready,
    output s_tready, m_data, m_ctrl, m_tlast, m_mty, m_tvalid
  );
  modport master (
    output s_data, s_ctrl, s_tlast, s_mty, s_tvalid, m_tready,
    input  s_tready, m_data, m_ctrl, m_tlast, m_mty, m_tvalid
  );
endinterface

// File: rtl/dma_pcie_mdma_rr_pick.sv
// dma_pcie_mdma_rr_pick: combinational round-robin pick of the first requester at or after ptr.
module dma_pcie_mdma_rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         vld,
  output logic [W-1:0] idx
);
  always_comb begin
    vld = 1'b0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        vld = 1'b1;
        idx = W'((int'(ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/dma_pcie_mdma_c2h_axis_arb.sv
// dma_pcie_mdma_c2h_axis_arb: round-robin packet arbiter merging NUM_SRC C2H streams onto one
// registered stream; a granted source owns the output until its tlast beat is accepted.
module dma_pcie_mdma_c2h_axis_arb
  import dma_pcie_mdma_c2h_axis_arb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = $clog2(NUM_SRC)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  dma_pcie_mdma_c2h_axis_arb_if.slave  bus,
  output logic [SRC_W-1:0]             grant_idx,
  output logic                         busy,
  output logic [15:0]                  pkt_cnt
);
  c2h_arb_state_e   state_q, state_d;
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d, grant_q, grant_d, pick_idx, src;
  logic [15:0]      pkt_cnt_q, pkt_cnt_d;
  c2h_beat_t        out_q, out_d, in_beat;
  logic             m_tvalid_q, m_tvalid_d;
  logic             out_en, pick_vld, sel, acc, last;

  dma_pcie_mdma_rr_pick #(.N(NUM_SRC), .W(SRC_W)) u_pick (
    .req(bus.s_tvalid),
    .ptr(rr_ptr_q),
    .vld(pick_vld),
    .idx(pick_idx)
  );

  // s_tready is gated by rst_n so nothing looks accepted while reset is held
  always_comb begin
    out_en       = !m_tvalid_q || bus.m_tready;
    src          = state_q == ARB_BUSY ? grant_q : pick_idx;
    sel          = state_q == ARB_BUSY || pick_vld;
    acc          = sel && bus.s_tvalid[src] && out_en;
    in_beat      = {bus.s_data[src], bus.s_ctrl[src], bus.s_tlast[src], bus.s_mty[src]};
    last         = acc && in_beat.tlast;
    state_d      = acc ? (in_beat.tlast ? ARB_IDLE : ARB_BUSY) : state_q;
    grant_d      = acc ? src : grant_q;
    rr_ptr_d     = last ? (32'(src) == NUM_SRC - 1 ? '0 : src + 1'b1) : rr_ptr_q;
    pkt_cnt_d    = pkt_cnt_q + {15'd0, last};
    m_tvalid_d   = out_en ? acc : m_tvalid_q;
    out_d        = acc ? in_beat : out_q;
    bus.s_tready = (sel && out_en && rst_n) ? NUM_SRC'(1) << src : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      pkt_cnt_q  <= '0;
      m_tvalid_q <= 1'b0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      pkt_cnt_q  <= pkt_cnt_d;
      m_tvalid_q <= m_tvalid_d;
      out_q      <= out_d;
    end
  end

  assign grant_idx    = grant_q;
  assign busy         = state_q == ARB_BUSY;
  assign pkt_cnt      = pkt_cnt_q;
  assign bus.m_tvalid = m_tvalid_q;
  assign bus.m_data   = out_q.data;
  assign bus.m_ctrl   = out_q.ctrl;
  assign bus.m_tlast  = out_q.tlast;
  assign bus.m_mty    = out_q.mty;
endmodule

// File: tb/tb_dma_pcie_mdma_c2h_axis_arb.sv
// tb_dma_pcie_mdma_c2h_axis_arb: randomized packet sources checked cycle by cycle against a
// packet-level round-robin reference model, plus directed ordering/backpressure/reset scenarios.
module tb_dma_pcie_mdma_c2h_axis_arb;
  import dma_pcie_mdma_c2h_axis_arb_pkg::*;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  grant_idx;
  logic        busy;
  logic [15:0] pkt_cnt;

  dma_pcie_mdma_c2h_axis_arb_if #(.NUM_SRC(N)) bus ();

  dma_pcie_mdma_c2h_axis_arb #(.NUM_SRC(N)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .grant_idx(grant_idx),
    .busy(busy),
    .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0, passed = 0, cyc = 0, pkt_seq = 0;
  int gap_pct = 0, rdy_pct = 100;
  c2h_beat_t src_q[N][$];
  logic [N-1:0] hs_rec = '0;
  int obs_src[$], obs_cyc[$];

  // reference model: packet owner (-1 = none), rr pointer, counters, output register contents
  int          owner = -1, ptr = 0;
  logic [1:0]  exp_grant = '0;
  logic [15:0] exp_cnt = '0;
  bit          exp_valid = 1'b0;
  c2h_beat_t   exp_beat = '0;

  function automatic bit pending();
    for (int s = 0; s < N; s++) if (src_q[s].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    owner = -1;
    ptr = 0;
    exp_grant = '0;
    exp_cnt = '0;
    exp_valid = 1'b0;
    exp_beat = '0;
    hs_rec = '0;
    for (int s = 0; s < N; s++) src_q[s].delete();
  endtask

  task automatic add_pkt(input int s, input int len);
    c2h_beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data  = {8'(s), 8'(pkt_seq), 16'(i), 32'($urandom)};
      b.ctrl  = '{qid: 11'(s), port_id: 3'($urandom), marker: 1'($urandom), len: 16'(len)};
      b.tlast = (i == len - 1);
      b.mty   = 6'($urandom);
      src_q[s].push_back(b);
    end
    pkt_seq++;
  endtask

  task automatic drive();
    c2h_beat_t b;
    for (int s = 0; s < N; s++) begin
      if (hs_rec[s] && src_q[s].size() > 0) src_q[s].delete(0);
      b = '0;
      b.data = {$urandom, $urandom};
      if (src_q[s].size() > 0) b = src_q[s][0];
      bus.s_tvalid[s] = src_q[s].size() > 0 && int'($urandom_range(99)) >= gap_pct;
      {bus.s_data[s], bus.s_ctrl[s], bus.s_tlast[s], bus.s_mty[s]} = b;
    end
    bus.m_tready = int'($urandom_range(99)) < rdy_pct;
    hs_rec = '0;
  endtask

  task automatic monitor();
    c2h_beat_t    mb;
    logic [N-1:0] hs;
    int           want, got;
    bit           oen;
    mb = {bus.m_data, bus.m_ctrl, bus.m_tlast, bus.m_mty};
    hs = bus.s_tvalid & bus.s_tready;
    checks++;
    if ($countones(bus.s_tready) > 1) $display("FAIL onehot cyc %0d: s_tready=%b", cyc, bus.s_tready);
    else passed++;
    if (owner < 0) begin
      checks++;
      if ((bus.s_tready & ~bus.s_tvalid) !== '0)
        $display("FAIL idle_ready cyc %0d: s_tready=%b s_tvalid=%b", cyc, bus.s_tready, bus.s_tvalid);
      else passed++;
    end
    checks++;
    if (bus.m_tvalid !== exp_valid) $display("FAIL m_tvalid cyc %0d: got %b want %b", cyc, bus.m_tvalid, exp_valid);
    else passed++;
    if (exp_valid) begin
      checks++;
      if (mb !== exp_beat) $display("FAIL m_beat cyc %0d: got %h want %h", cyc, mb, exp_beat);
      else passed++;
    end
    checks++;
    if (busy !== (owner >= 0)) $display("FAIL busy cyc %0d: got %b want %b", cyc, busy, owner >= 0);
    else passed++;
    checks++;
    if (grant_idx !== exp_grant) $display("FAIL grant_idx cyc %0d: got %0d want %0d", cyc, grant_idx, exp_grant);
    else passed++;
    checks++;
    if (pkt_cnt !== exp_cnt) $display("FAIL pkt_cnt cyc %0d: got %h want %h", cyc, pkt_cnt, exp_cnt);
    else passed++;
    oen = !exp_valid || bus.m_tready;
    want = -1;
    if (oen) begin
      if (owner >= 0) want = bus.s_tvalid[owner] ? owner : -1;
      else for (int k = 0; k < N; k++) if (want < 0 && bus.s_tvalid[(ptr + k) % N]) want = (ptr + k) % N;
    end
    got = -1;
    for (int i = 0; i < N; i++) if (hs[i]) got = i;
    checks++;
    if (got != want) $display("FAIL accept cyc %0d: got src %0d want src %0d", cyc, got, want);
    else passed++;
    if (bus.m_tvalid && bus.m_tready) begin
      obs_src.push_back(int'(bus.m_ctrl.qid));
      obs_cyc.push_back(cyc);
    end
    if (oen) begin
      exp_valid = want >= 0;
      if (want >= 0) exp_beat = src_q[want][0];
    end
    if (want >= 0) begin
      exp_grant = 2'(want);
      if (src_q[want][0].tlast) begin
        owner = -1;
        ptr = (want + 1) % N;
        exp_cnt++;
      end else owner = want;
    end
    hs_rec = hs;
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((pending() || exp_valid) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (pending() || exp_valid) $display("FAIL %s drain: still pending after %0d cycles", name, budget);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.m_tready = 1'b1;
    bus.s_tvalid = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 6;
    if (bus.s_tready !== '0) $display("FAIL reset s_tready: got %b want 0", bus.s_tready); else passed++;
    if (bus.m_tvalid !== 1'b0) $display("FAIL reset m_tvalid: got %b want 0", bus.m_tvalid); else passed++;
    if ({bus.m_data, bus.m_ctrl, bus.m_tlast, bus.m_mty} !== '0) $display("FAIL reset m_beat: not zero"); else passed++;
    if (busy !== 1'b0) $display("FAIL reset busy: got %b want 0", busy); else passed++;
    if (grant_idx !== 2'd0) $display("FAIL reset grant_idx: got %0d want 0", grant_idx); else passed++;
    if (pkt_cnt !== 16'd0) $display("FAIL reset pkt_cnt: got %h want 0", pkt_cnt); else passed++;
    bus.s_tvalid = '0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive();
  endtask

  task automatic test_rr_order();
    obs_src.delete(); obs_cyc.delete();
    for (int s = 0; s < N; s++) add_pkt(s, 3);
    drive();
    drain("rr_order", 100);
    checks++;
    if (obs_src.size() != 12) $display("FAIL rr_order beats: got %0d want 12", obs_src.size());
    else begin
      passed++;
      for (int i = 0; i < 12; i++) begin
        checks++;
        if (obs_src[i] != i / 3) $display("FAIL rr_order src beat %0d: got %0d want %0d", i, obs_src[i], i / 3);
        else passed++;
      end
      checks++;
      if (obs_cyc[11] - obs_cyc[0] != 11) $display("FAIL rr_order contiguous: span %0d want 11", obs_cyc[11] - obs_cyc[0]);
      else passed++;
    end
    checks++;
    if (pkt_cnt !== 16'd4) $display("FAIL rr_order pkt_cnt: got %0d want 4", pkt_cnt); else passed++;
  endtask

  task automatic test_no_preempt();
    int n = 0;
    int exp_order[8] = '{2, 2, 2, 2, 3, 3, 0, 0};
    obs_src.delete(); obs_cyc.delete();
    add_pkt(2, 4);
    drive();
    while (owner != 2 && n < 20) begin step(); n++; end
    add_pkt(0, 2);
    add_pkt(3, 2);
    drive();
    n = 0;
    while (owner == 2 && n < 20) begin
      #2;
      checks++;
      if (bus.s_tready[0] !== 1'b0) $display("FAIL no_preempt s_tready0: got %b want 0", bus.s_tready[0]);
      else passed++;
      step();
      n++;
    end
    drain("no_preempt", 100);
    checks++;
    if (obs_src.size() != 8) $display("FAIL no_preempt beats: got %0d want 8", obs_src.size());
    else begin
      passed++;
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (obs_src[i] != exp_order[i]) $display("FAIL no_preempt order %0d: got %0d want %0d", i, obs_src[i], exp_order[i]);
        else passed++;
      end
    end
  endtask

  task automatic test_backpressure();
    c2h_beat_t first;
    obs_src.delete(); obs_cyc.delete();
    add_pkt(1, 6);
    first = src_q[1][0];
    drive();
    step();
    rdy_pct = 0;
    bus.m_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #2;
      checks += 3;
      if (bus.s_tready !== '0) $display("FAIL stall s_tready %0d: got %b want 0", i, bus.s_tready); else passed++;
      if (bus.m_tvalid !== 1'b1) $display("FAIL stall m_tvalid %0d: got %b want 1", i, bus.m_tvalid); else passed++;
      if ({bus.m_data, bus.m_ctrl, bus.m_tlast, bus.m_mty} !== first)
        $display("FAIL stall m_beat %0d: got %h want %h", i, {bus.m_data, bus.m_ctrl, bus.m_tlast, bus.m_mty}, first);
      else passed++;
      step();
    end
    rdy_pct = 100;
    bus.m_tready = 1'b1;
    drain("backpressure", 100);
    checks++;
    if (obs_src.size() != 6) $display("FAIL backpressure beats: got %0d want 6", obs_src.size());
    else begin
      passed++;
      checks++;
      if (obs_cyc[1] - obs_cyc[0] != 1) $display("FAIL backpressure follow: gap %0d want 1", obs_cyc[1] - obs_cyc[0]);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    logic [15:0] base;
    base = exp_cnt;
    obs_src.delete(); obs_cyc.delete();
    for (int i = 0; i < 8; i++) add_pkt(1, 1);
    drive();
    while ((pending() || exp_valid) && n < 40) begin
      #2;
      checks++;
      if (busy !== 1'b0) $display("FAIL b2b busy: got %b want 0", busy); else passed++;
      step();
      n++;
    end
    checks++;
    if (obs_src.size() != 8) $display("FAIL b2b beats: got %0d want 8", obs_src.size());
    else begin
      passed++;
      checks++;
      if (obs_cyc[7] - obs_cyc[0] != 7) $display("FAIL b2b contiguous: span %0d want 7", obs_cyc[7] - obs_cyc[0]);
      else passed++;
    end
    checks++;
    if (pkt_cnt !== base + 16'd8) $display("FAIL b2b pkt_cnt: got %0d want %0d", pkt_cnt, base + 16'd8);
    else passed++;
  endtask

  task automatic test_random();
    int total = 0, len;
    obs_src.delete(); obs_cyc.delete();
    gap_pct = 30;
    rdy_pct = 70;
    for (int i = 0; i < 24; i++) begin
      len = int'($urandom_range(5, 1));
      add_pkt(int'($urandom_range(N - 1)), len);
      total += len;
    end
    drive();
    drain("random", 3000);
    gap_pct = 0;
    rdy_pct = 100;
    checks++;
    if (obs_src.size() != total) $display("FAIL random beats: got %0d want %0d", obs_src.size(), total);
    else passed++;
  endtask

  task automatic test_wrap();
    force dut.pkt_cnt_q = 16'hFFFE;
    #1 release dut.pkt_cnt_q;
    exp_cnt = 16'hFFFE;
    add_pkt(0, 2);
    add_pkt(2, 1);
    drive();
    drain("wrap", 100);
    checks++;
    if (pkt_cnt !== 16'h0000) $display("FAIL wrap pkt_cnt: got %h want 0000", pkt_cnt); else passed++;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    add_pkt(2, 4);
    drive();
    while (src_q[2].size() > 2 && n < 20) begin step(); n++; end
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (bus.m_tvalid !== 1'b0) $display("FAIL midrst m_tvalid: got %b want 0", bus.m_tvalid); else passed++;
    if (busy !== 1'b0) $display("FAIL midrst busy: got %b want 0", busy); else passed++;
    if (bus.s_tready !== '0) $display("FAIL midrst s_tready: got %b want 0", bus.s_tready); else passed++;
    if (grant_idx !== 2'd0) $display("FAIL midrst grant_idx: got %0d want 0", grant_idx); else passed++;
    model_reset();
    bus.s_tvalid = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    obs_src.delete(); obs_cyc.delete();
    add_pkt(3, 1);
    add_pkt(2, 1);
    add_pkt(0, 1);
    drive();
    drain("midrst", 100);
    checks++;
    if (obs_src.size() != 3) $display("FAIL midrst beats: got %0d want 3", obs_src.size());
    else begin
      passed++;
      checks++;
      if (obs_src[0] != 0) $display("FAIL midrst first src: got %0d want 0", obs_src[0]); else passed++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_rr_order();
    test_no_preempt();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/dma_pcie_mdma_c2h_axis_arb.md
DMA_PCIE_MDMA_C2H_AXIS_ARB -- requirements
Module: dma_pcie_mdma_c2h_axis_arb

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, number of C2H stream requesters (2..8).
REQ-002 SHALL have parameter SRC_W, default $clog2(NUM_SRC), grant index width.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port s_data, input, NUM_SRC x mdma_c2h_axis_data_t, per-source beat data.
REQ-006 SHALL have port s_ctrl, input, NUM_SRC x mdma_c2h_axis_ctrl_t, per-source packet control.
REQ-007 SHALL have port s_tlast, input, NUM_SRC, per-source end of packet.
REQ-008 SHALL have port s_mty, input, NUM_SRC x 6, per-source empty-byte count.
REQ-009 SHALL have port s_tvalid, input, NUM_SRC, per-source beat valid.
REQ-010 SHALL have port s_tready, output, NUM_SRC, per-source beat accept.
REQ-011 SHALL have ports m_data/m_ctrl/m_tlast/m_mty/m_tvalid, outputs, with the same types as one source, driving the shared C2H stream.
REQ-012 SHALL have port m_tready, input, 1, shared C2H stream accept.
REQ-013 SHALL have port grant_idx, output, SRC_W, index of current or last granted source.
REQ-014 SHALL have port busy, output, 1, high while a packet is mid-transfer (state BUSY).
REQ-015 SHALL have port pkt_cnt, output, 16, count of packets forwarded to the output register; wraps 0xFFFF->0.

Function
REQ-016 SHALL implement a two-state FSM: IDLE (no packet owned), BUSY (source grant_idx owns the output until its tlast is accepted).
REQ-017 SHALL define out_en = !m_tvalid || m_tready; output register loads only when out_en=1.
REQ-018 In IDLE, SHALL pick winner = first index i with s_tvalid[i]=1 scanning rr_ptr, rr_ptr+1, ... mod NUM_SRC; this is combinational in the same cycle.
REQ-019 In IDLE with a winner, SHALL assert s_tready[winner]=out_en; grant_idx shall update to winner on the accept clock edge.
REQ-020 On an accepted IDLE beat with s_tlast=0, SHALL go to BUSY; with s_tlast=1 (single-beat packet), SHALL remain IDLE.
REQ-021 In BUSY, SHALL assert s_tready[grant_idx]=out_en and hold all other s_tready at 0; no re-arbitration mid-packet.
REQ-022 On any accepted beat with s_tlast=1, SHALL set rr_ptr=(source+1) mod NUM_SRC, increment pkt_cnt, and enter IDLE.
REQ-023 SHALL never assert more than one s_tready bit in a cycle; s_tready of a source with s_tvalid=0 is don't-care but SHALL be 0 in IDLE.
REQ-024 An accepted beat SHALL appear on m_* exactly one cycle later (latency 1); throughput SHALL be one beat per cycle while m_tready=1.
REQ-025 m_* data, ctrl, tlast and mty SHALL be stable while m_tvalid=1 and m_tready=0.
REQ-026 If out_en=0, SHALL accept nothing and FSM/rr_ptr SHALL hold.
REQ-027 A source deasserting s_tvalid mid-packet in BUSY SHALL keep ownership; idle cycles are forwarded as m_tvalid=0.
REQ-028 The last beat's mty SHALL pass through unmodified; non-last beats' mty is forwarded as received.

Reset
REQ-029 On rst_n=0, SHALL asynchronously force: state IDLE, rr_ptr=0, grant_idx=0, busy=0, pkt_cnt=0, m_tvalid=0, s_tready=0; m_data/m_ctrl/m_mty/m_tlast cleared to 0.
REQ-030 Reset mid-packet SHALL discard the partial packet; after release, arbitration restarts from source 0 with no residual grant.

Structure
REQ-031 mdma_c2h_axis_data_t and mdma_c2h_axis_ctrl_t SHALL come from the shared CPM MDMA defines; C2H_ARB_MAX_SRC=8 and the FSM state enum SHALL be added there.
REQ-032 Round-robin winner selection SHALL be a sub-module dma_pcie_mdma_rr_pick (inputs req, ptr; outputs vld, idx), combinational.

Verification
REQ-033 Sources 0..3 each send one 3-beat packet simultaneously, m_tready=1 -> output order 0,1,2,3, 12 contiguous beats, pkt_cnt=4, no interleaving.
REQ-034 Source 2 mid-packet, source 0 raises s_tvalid -> s_tready[0]=0 until source 2 tlast accepted; next grant_idx=3 if valid else 0.
REQ-035 m_tready held 0 for 5 cycles with m_tvalid=1 -> m_* unchanged, all s_tready=0; on release, next beat follows next cycle.
REQ-036 Source 1 sends eight 1-beat packets while sources 0/3 idle -> 8 back-to-back beats, busy stays 0, pkt_cnt=8.
REQ-037 Preload pkt_cnt near 0xFFFF, send 2 packets -> pkt_cnt wraps 0xFFFF->0x0000.
REQ-038 rst_n pulsed low during beat 2 of a 4-beat packet -> m_tvalid=0 immediately, busy=0; after release source 0 wins first.
